regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_W, default 32, sets the register data width.
REQ-002 Parameter ADDR_W, default 5, sets the register address width.
REQ-003 Parameter NUM_REGS, default 32, sets the number of architectural registers, equal to 2**ADDR_W.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 we  input  1  write enable from the write-back stage.
REQ-007 waddr  input  ADDR_W  write register index.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 re1  input  1  read port 1 enable, driven by the decode stage's reg1 read request.
REQ-010 raddr1  input  ADDR_W  read port 1 register index.
REQ-011 rdata1  output  DATA_W  read port 1 data, combinational.
REQ-012 re2  input  1  read port 2 enable, driven by the decode stage's reg2 read request.
REQ-013 raddr2  input  ADDR_W  read port 2 register index.
REQ-014 rdata2  output  DATA_W  read port 2 data, combinational.
REQ-015 dbg_req  input  1  debug read request, single-cycle pulse.
REQ-016 dbg_addr  input  ADDR_W  debug read index.
REQ-017 dbg_data  output  DATA_W  registered debug read data.
REQ-018 dbg_valid  output  1  one-cycle strobe qualifying dbg_data.
REQ-019 dirty  output  NUM_REGS  per-register flag: written since reset.

Function
REQ-020 Storage SHALL be NUM_REGS x DATA_W flops, written on the rising clk edge when we=1 and waddr!=0.
REQ-021 Register 0 SHALL read as zero on every port, and writes to it SHALL be discarded with dirty[0] held at 0.
REQ-022 rdata1 SHALL be zero when rst_n=0, re1=0, or raddr1=0.
REQ-023 When re1=1, we=1 and raddr1==waddr!=0, rdata1 SHALL equal wdata in the same cycle (write-through bypass).
REQ-024 Otherwise, with re1=1, rdata1 SHALL equal the stored value at raddr1.
REQ-025 REQ-022 to REQ-024 SHALL apply identically to port 2 (re2, raddr2, rdata2); port 2 SHALL never source port 1 data.
REQ-026 Both read ports and the write port SHALL operate concurrently every cycle; identical raddr1/raddr2 SHALL return identical data.
REQ-027 dirty[waddr] SHALL set on the edge that commits a write to waddr!=0 and clear only on reset.
REQ-028 Debug path, two-state machine: IDLE and RESP.
REQ-029 IDLE->RESP on a clk edge with dbg_req=1: dbg_data SHALL capture the REQ-022 to REQ-024 read result for dbg_addr with enable=1, including bypass of a same-cycle write.
REQ-030 In RESP, dbg_valid SHALL be 1 for exactly one cycle; RESP->IDLE unconditionally on the next edge.
REQ-031 dbg_req asserted while in RESP SHALL be ignored; no queuing.
REQ-032 dbg_data SHALL hold its last captured value until the next capture.

Reset
REQ-033 While rst_n=0, all storage, dirty and dbg_data SHALL be zero, dbg_valid SHALL be 0, the debug FSM SHALL be IDLE, and rdata1/rdata2 SHALL be zero.
REQ-034 Reset assertion SHALL take effect immediately without clk; a write or debug capture in flight SHALL be discarded.
REQ-035 After rst_n deasserts, the first rising clk edge SHALL accept writes and debug requests normally.

Verification
REQ-036 Write-then-read: we=1 waddr=5 wdata=0x1234_5678, next cycle re1=1 raddr1=5 -> rdata1=0x1234_5678 and dirty[5]=1.
REQ-037 Bypass: same cycle we=1 waddr=9 wdata=0xDEAD_BEEF, re1=re2=1, raddr1=raddr2=9 -> rdata1=rdata2=0xDEAD_BEEF before the edge.
REQ-038 Zero register: we=1 waddr=0 wdata=0xFFFF_FFFF, then re1=1 raddr1=0 -> rdata1=0 and dirty[0]=0.
REQ-039 Disabled port: reg 3 holds 0xA5A5_A5A5, re2=0 raddr2=3 -> rdata2=0.
REQ-040 Debug: reg 7 holds 0x0000_00FF; pulse dbg_req with dbg_addr=7 -> next cycle dbg_valid=1 and dbg_data=0xFF; a second dbg_req in RESP produces no extra dbg_valid.
REQ-041 Async reset: registers populated, assert rst_n=0 mid-cycle with no clk edge -> rdata1, rdata2, dirty and dbg_data read 0 immediately.

Source files
------------

// File: rtl/regfile_if.sv
// Bundles the write-back, decode read and debug signals of the register file.
interface regfile_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 2**ADDR_W
);
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                re1;
    logic [ADDR_W-1:0]   raddr1;
    logic [DATA_W-1:0]   rdata1;
    logic                re2;
    logic [ADDR_W-1:0]   raddr2;
    logic [DATA_W-1:0]   rdata2;
    logic                dbg_req;
    logic [ADDR_W-1:0]   dbg_addr;
    logic [DATA_W-1:0]   dbg_data;
    logic                dbg_valid;
    logic [NUM_REGS-1:0] dirty;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_req, dbg_addr,
        input  rdata1, rdata2, dbg_data, dbg_valid, dirty
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_req, dbg_addr,
        output rdata1, rdata2, dbg_data, dbg_valid, dirty
    );
endinterface

// File: rtl/regfile.sv
// Two-read/one-write register file with write-through bypass, zero register,
// per-register dirty flags and a single-outstanding registered debug read.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input logic      clk,
    input logic      rst_n,
    regfile_if.slave bus
);
    typedef enum logic {S_IDLE, S_RESP} state_t;

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_dirty;
    logic [DATA_W-1:0]   r_dbg_data;
    state_t              r_state;
    state_t              w_state_next;
    logic                w_capture;
    logic                w_wr_ok;

    // Lookup slots: 0 = read port 1, 1 = read port 2, 2 = debug (always enabled)
    logic              w_en   [3];
    logic [ADDR_W-1:0] w_addr [3];
    logic [DATA_W-1:0] w_rd   [3];

    assign w_en[0]   = bus.re1;
    assign w_addr[0] = bus.raddr1;
    assign w_en[1]   = bus.re2;
    assign w_addr[1] = bus.raddr2;
    assign w_en[2]   = 1'b1;
    assign w_addr[2] = bus.dbg_addr;

    assign w_wr_ok = bus.we && (bus.waddr != '0);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rd
            always_comb begin
                w_rd[gi] = '0;
                if (rst_n && w_en[gi] && (w_addr[gi] != '0)) begin
                    if (w_wr_ok && (bus.waddr == w_addr[gi]))
                        w_rd[gi] = bus.wdata;
                    else
                        w_rd[gi] = r_mem[w_addr[gi]];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
            r_dirty <= '0;
        end else if (w_wr_ok) begin
            r_mem[bus.waddr]   <= bus.wdata;
            r_dirty[bus.waddr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dbg_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) r_dbg_data <= w_rd[2];
        end
    end

    // Requests arriving while a response is showing are dropped, not queued
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.dbg_req) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.rdata1    = w_rd[0];
    assign bus.rdata2    = w_rd[1];
    assign bus.dbg_data  = r_dbg_data;
    assign bus.dbg_valid = (r_state == S_RESP);
    assign bus.dirty     = r_dirty;
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a per-cycle compare against an array model plus
// literal expectations for the headline scenarios.
module tb_regfile;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) bus ();

    regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [DW-1:0] mdl_mem [NR];
    logic [NR-1:0] mdl_dirty;
    logic [DW-1:0] mdl_dbg_data;
    logic          mdl_busy;

    function automatic logic [DW-1:0] mread(input logic en, input logic [AW-1:0] a);
        if (!rst_n || !en || a == 0) return '0;
        if (bus.we && bus.waddr == a) return bus.wdata;
        return mdl_mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) mdl_mem[i] <= '0;
            mdl_dirty    <= '0;
            mdl_dbg_data <= '0;
            mdl_busy     <= 1'b0;
        end else begin
            if (mdl_busy) begin
                mdl_busy <= 1'b0;
            end else if (bus.dbg_req) begin
                mdl_dbg_data <= mread(1'b1, bus.dbg_addr);
                mdl_busy     <= 1'b1;
            end
            if (bus.we && bus.waddr != 0) begin
                mdl_mem[bus.waddr]   <= bus.wdata;
                mdl_dirty[bus.waddr] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("rdata1",    bus.rdata1,            mread(bus.re1, bus.raddr1));
        check("rdata2",    bus.rdata2,            mread(bus.re2, bus.raddr2));
        check("dirty",     bus.dirty,             mdl_dirty);
        check("dbg_valid", {31'd0, bus.dbg_valid}, {31'd0, mdl_busy});
        check("dbg_data",  bus.dbg_data,          mdl_dbg_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.we = 0; bus.waddr = 0; bus.wdata = 0;
        bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
        bus.dbg_req = 0; bus.dbg_addr = 0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we = 1; bus.waddr = a; bus.wdata = d;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        idle_in();
        step(); step();
        check("rst_dirty",     bus.dirty, 32'h0);
        check("rst_dbg_valid", {31'd0, bus.dbg_valid}, 32'h0);
        bus.re1 = 1; bus.raddr1 = 5;
        #1 check("rst_rdata1", bus.rdata1, 32'h0);
        #1 rst_n = 1'b1;
        step();

        // Write then read
        idle_in(); wr(5, 32'h1234_5678);
        step();
        idle_in(); bus.re1 = 1; bus.raddr1 = 5;
        #2 check("wr_rd_rdata1", bus.rdata1, 32'h1234_5678);
        check("wr_rd_dirty5", {31'd0, bus.dirty[5]}, 32'h1);
        step();

        // Same-cycle bypass on both ports
        idle_in(); wr(9, 32'hDEAD_BEEF);
        bus.re1 = 1; bus.raddr1 = 9; bus.re2 = 1; bus.raddr2 = 9;
        #2 check("byp_rdata1", bus.rdata1, 32'hDEAD_BEEF);
        check("byp_rdata2", bus.rdata2, 32'hDEAD_BEEF);
        step();

        // Zero register
        idle_in(); wr(0, 32'hFFFF_FFFF);
        bus.re1 = 1; bus.raddr1 = 0;
        #2 check("zero_byp_rdata1", bus.rdata1, 32'h0);
        step();
        idle_in(); bus.re1 = 1; bus.raddr1 = 0;
        #2 check("zero_rdata1", bus.rdata1, 32'h0);
        check("zero_dirty0", {31'd0, bus.dirty[0]}, 32'h0);
        step();

        // Disabled port
        idle_in(); wr(3, 32'hA5A5_A5A5);
        step();
        idle_in(); bus.re2 = 0; bus.raddr2 = 3; bus.re1 = 1; bus.raddr1 = 3;
        #2 check("dis_rdata2", bus.rdata2, 32'h0);
        check("en_rdata1", bus.rdata1, 32'hA5A5_A5A5);
        step();

        // Debug read and ignored request during response
        idle_in(); wr(7, 32'h0000_00FF);
        step();
        idle_in(); bus.dbg_req = 1; bus.dbg_addr = 7;
        step();
        #2 check("dbg_valid1", {31'd0, bus.dbg_valid}, 32'h1);
        check("dbg_data", bus.dbg_data, 32'h0000_00FF);
        step();
        bus.dbg_req = 0;
        #2 check("dbg_valid_ign", {31'd0, bus.dbg_valid}, 32'h0);
        step();
        #2 check("dbg_valid_idle", {31'd0, bus.dbg_valid}, 32'h0);
        check("dbg_hold", bus.dbg_data, 32'h0000_00FF);

        // Debug capture bypasses a same-cycle write
        idle_in(); wr(12, 32'hCAFE_0012); bus.dbg_req = 1; bus.dbg_addr = 12;
        step();
        idle_in();
        #2 check("dbg_byp", bus.dbg_data, 32'hCAFE_0012);
        step();

        // Asynchronous reset mid-cycle, with a write pending
        idle_in(); bus.re1 = 1; bus.raddr1 = 5; bus.re2 = 1; bus.raddr2 = 9;
        wr(20, 32'h0BAD_F00D);
        #1 check("pre_rst_rdata1", bus.rdata1, 32'h1234_5678);
        #1 rst_n = 1'b0;
        #1 check("arst_rdata1", bus.rdata1, 32'h0);
        check("arst_rdata2", bus.rdata2, 32'h0);
        check("arst_dirty", bus.dirty, 32'h0);
        check("arst_dbg_data", bus.dbg_data, 32'h0);
        step();
        bus.we = 0;
        #1 rst_n = 1'b1;
        step();
        check("post_rst_dirty", bus.dirty, 32'h0);

        // First edges after reset work normally
        idle_in(); wr(4, 32'h4444_0004); bus.dbg_req = 1; bus.dbg_addr = 4;
        step();
        idle_in();
        #2 check("post_rst_wr", bus.dirty, 32'h0000_0010);
        check("post_rst_dbg", bus.dbg_data, 32'h4444_0004);
        step();

        // Sweep of writes with concurrent reads (model checks every cycle)
        for (int i = 1; i < NR; i++) begin
            idle_in();
            wr(AW'(i), (32'h0101_0101 * i) ^ 32'h5A);
            bus.re1 = 1; bus.raddr1 = AW'(i - 1);
            bus.re2 = 1; bus.raddr2 = AW'(i);
            bus.dbg_req = (i % 3 == 0); bus.dbg_addr = AW'(i - 2);
            step();
        end
        idle_in(); bus.re1 = 1; bus.raddr1 = 31; bus.re2 = 1; bus.raddr2 = 31;
        #2 check("sweep_r31", bus.rdata1, 32'h1F1F_1F45);
        check("sweep_same", bus.rdata2, 32'h1F1F_1F45);
        check("sweep_dirty", bus.dirty, 32'hFFFF_FFFE);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
